// File: rtl/vadd_host_pkg.sv
// Shared widths and FSM state types for the vector-add host stream bridge.
// Optional s_elem_last framing check is enabled by VADD_HOST_LASTCHK_EN.
package vadd_host_pkg;

    localparam int N         = 11;
    localparam int IN_W      = 10;
    localparam int OUT_W     = 11;
    localparam int ACC_IN_W  = 2 * N * IN_W;
    localparam int ACC_OUT_W = N * OUT_W;
    localparam int BEATS     = 2 * N;

    typedef enum logic {
        FILL,
        SEND
    } pack_state_t;

    typedef enum logic {
        IDLE,
        EMIT
    } unpack_state_t;

endpackage

// File: rtl/vector_add_11_stream_host_unpacker.sv
// Unpack path: captures one 121-bit result word and replays it as 11 sum beats.
// Module name is vadd_elem_unpacker; S0 is the most significant slot.
module vadd_elem_unpacker
    import vadd_host_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [ACC_OUT_W-1:0] res_data,
    input  logic                 res_valid,
    output logic                 res_ready,
    output logic [OUT_W-1:0]     m_elem_data,
    output logic                 m_elem_valid,
    output logic                 m_elem_last,
    input  logic                 m_elem_ready
);

    unpack_state_t        state, state_n;
    logic [3:0]           j;
    logic [ACC_OUT_W-1:0] res_word;
    logic                 r_hs, m_hs, final_beat;

    assign r_hs       = res_valid && res_ready;
    assign m_hs       = m_elem_valid && m_elem_ready;
    assign final_beat = (j == 4'(N - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (r_hs) state_n = EMIT;
            EMIT: if (m_hs && final_beat) state_n = IDLE;
        endcase
    end

    // res_word holds the not-yet-emitted slots, left-aligned
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state        <= IDLE;
            j            <= '0;
            res_word     <= '0;
            res_ready    <= 1'b1;
            m_elem_valid <= 1'b0;
            m_elem_data  <= '0;
            m_elem_last  <= 1'b0;
        end else begin
            state <= state_n;
            if (r_hs) begin
                res_word     <= res_data << OUT_W;
                m_elem_data  <= res_data[ACC_OUT_W-1 -: OUT_W];
                m_elem_valid <= 1'b1;
                m_elem_last  <= 1'b0;
                res_ready    <= 1'b0;
                j            <= '0;
            end else if (m_hs) begin
                if (final_beat) begin
                    m_elem_valid <= 1'b0;
                    m_elem_last  <= 1'b0;
                    res_ready    <= 1'b1;
                    j            <= '0;
                end else begin
                    res_word    <= res_word << OUT_W;
                    m_elem_data <= res_word[ACC_OUT_W-1 -: OUT_W];
                    m_elem_last <= (j == 4'(N - 2));
                    j           <= j + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vector_add_11_stream_host.sv
// Host bridge: packs 22 operand beats into one word, unpacks 11 sum beats.
// Define VADD_HOST_LASTCHK_EN to add s_elem_last framing check and frame_err.
module vector_add_11_stream_host
    import vadd_host_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [IN_W-1:0]      s_elem_data,
    input  logic                 s_elem_valid,
    output logic                 s_elem_ready,
`ifdef VADD_HOST_LASTCHK_EN
    input  logic                 s_elem_last,
    output logic                 frame_err,
`endif
    output logic [ACC_IN_W-1:0]  acc_data,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    input  logic [ACC_OUT_W-1:0] res_data,
    input  logic                 res_valid,
    output logic                 res_ready,
    output logic [OUT_W-1:0]     m_elem_data,
    output logic                 m_elem_valid,
    output logic                 m_elem_last,
    input  logic                 m_elem_ready
);

    pack_state_t state, state_n;
    logic [4:0]  k, k_n;
    logic        acc_valid_n, s_ready_n;
    logic        s_hs, a_hs, last_beat;

    assign s_hs      = s_elem_valid && s_elem_ready;
    assign a_hs      = acc_valid && acc_ready;
    assign last_beat = (k == 5'(BEATS - 1));

`ifdef VADD_HOST_LASTCHK_EN
    logic err_n;
    assign err_n = s_hs && (s_elem_last != last_beat);
`endif

    always_comb begin
        state_n     = state;
        k_n         = k;
        acc_valid_n = acc_valid;
        s_ready_n   = s_elem_ready;
        unique case (state)
            FILL: begin
                if (s_hs) begin
                    if (last_beat) begin
                        state_n     = SEND;
                        k_n         = '0;
                        acc_valid_n = 1'b1;
                        s_ready_n   = 1'b0;
                    end
`ifdef VADD_HOST_LASTCHK_EN
                    else if (s_elem_last) begin
                        k_n = '0;
                    end
`endif
                    else begin
                        k_n = k + 5'd1;
                    end
                end
            end
            SEND: begin
                if (a_hs) begin
                    state_n     = FILL;
                    acc_valid_n = 1'b0;
                    s_ready_n   = 1'b1;
                end
            end
        endcase
    end

    // beat k lands in slot k counted from the MSB end
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state        <= FILL;
            k            <= '0;
            acc_valid    <= 1'b0;
            s_elem_ready <= 1'b1;
            acc_data     <= '0;
`ifdef VADD_HOST_LASTCHK_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            k            <= k_n;
            acc_valid    <= acc_valid_n;
            s_elem_ready <= s_ready_n;
            if (s_hs) begin
                acc_data[ACC_IN_W-1-int'(k)*IN_W -: IN_W] <= s_elem_data;
            end
`ifdef VADD_HOST_LASTCHK_EN
            frame_err    <= err_n;
`endif
        end
    end

    vadd_elem_unpacker u_unpack (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .m_elem_data  (m_elem_data),
        .m_elem_valid (m_elem_valid),
        .m_elem_last  (m_elem_last),
        .m_elem_ready (m_elem_ready)
    );

endmodule

// File: tb/tb_vector_add_11_stream_host.sv
// Scoreboard bench for vector_add_11_stream_host with random and directed traffic.
// Also covers the VADD_HOST_LASTCHK_EN framing check when that macro is defined.
module tb_vector_add_11_stream_host;
    import vadd_host_pkg::*;

    logic                 aclk;
    logic                 aresetn;
    logic [IN_W-1:0]      s_elem_data;
    logic                 s_elem_valid;
    logic                 s_elem_ready;
    logic [ACC_IN_W-1:0]  acc_data;
    logic                 acc_valid;
    logic                 acc_ready;
    logic [ACC_OUT_W-1:0] res_data;
    logic                 res_valid;
    logic                 res_ready;
    logic [OUT_W-1:0]     m_elem_data;
    logic                 m_elem_valid;
    logic                 m_elem_last;
    logic                 m_elem_ready;
`ifdef VADD_HOST_LASTCHK_EN
    logic                 s_elem_last;
    logic                 frame_err;
`endif

    logic acc_force, acc_rnd, acc_rand_en;
    logic m_force, m_tog, m_rnd;
    int   m_mode;

    assign acc_ready    = acc_rand_en ? acc_rnd : acc_force;
    assign m_elem_ready = (m_mode == 0) ? m_force :
                          (m_mode == 1) ? m_tog : m_rnd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ACC_IN_W-1:0] acc_q[$];
    logic [OUT_W:0]      sum_q[$];

    vector_add_11_stream_host dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_elem_data  (s_elem_data),
        .s_elem_valid (s_elem_valid),
        .s_elem_ready (s_elem_ready),
`ifdef VADD_HOST_LASTCHK_EN
        .s_elem_last  (s_elem_last),
        .frame_err    (frame_err),
`endif
        .acc_data     (acc_data),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .m_elem_data  (m_elem_data),
        .m_elem_valid (m_elem_valid),
        .m_elem_last  (m_elem_last),
        .m_elem_ready (m_elem_ready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string nm,
                         input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    always @(posedge aclk) begin
        #1;
        m_tog   = ~m_tog;
        m_rnd   = 1'($urandom_range(0, 1));
        acc_rnd = 1'($urandom_range(0, 1));
    end

    // acc monitor: word on the bus must equal the oldest expected word
    always @(negedge aclk) begin
        if (aresetn && acc_valid) begin
            if (acc_q.size() == 0) begin
                check(1'b0, "acc_unexpected", 256'(acc_data), 256'(0));
            end else begin
                check(acc_data == acc_q[0], "acc_data",
                      256'(acc_data), 256'(acc_q[0]));
                if (acc_ready) void'(acc_q.pop_front());
            end
        end
    end

    // sum monitor: {last,data} compared against the model's beat list
    always @(negedge aclk) begin
        if (aresetn && m_elem_valid) begin
            if (sum_q.size() == 0) begin
                check(1'b0, "sum_unexpected", 256'({m_elem_last, m_elem_data}), 256'(0));
            end else begin
                check({m_elem_last, m_elem_data} == sum_q[0], "sum_beat",
                      256'({m_elem_last, m_elem_data}), 256'(sum_q[0]));
                if (m_elem_ready) void'(sum_q.pop_front());
            end
        end
    end

    task automatic put_beat(input logic [IN_W-1:0] d);
        int  n;
        bit  hs;
        s_elem_valid = 1'b1;
        s_elem_data  = d;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 300) begin
            @(negedge aclk);
            hs = s_elem_ready;
            @(posedge aclk);
            #1;
            n++;
        end
        if (!hs) check(1'b0, "pack_timeout", 256'(0), 256'(1));
    endtask

    task automatic pack_frame(input bit seq, input int gap_max, input int nbeats);
        logic [ACC_IN_W-1:0] w;
        logic [IN_W-1:0]     e;
        int                  g;
        w = '0;
        for (int i = 0; i < nbeats; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            if (g > 0) begin
                s_elem_valid = 1'b0;
                repeat (g) begin
                    @(posedge aclk);
                    #1;
                end
            end
            e = seq ? IN_W'(i + 1) : IN_W'($urandom);
            w = (w << IN_W) | ACC_IN_W'(e);
`ifdef VADD_HOST_LASTCHK_EN
            s_elem_last = (i == BEATS - 1);
`endif
            put_beat(e);
        end
        s_elem_valid = 1'b0;
`ifdef VADD_HOST_LASTCHK_EN
        s_elem_last = 1'b0;
`endif
        if (nbeats == BEATS) acc_q.push_back(w);
    endtask

    task automatic send_result(input logic [ACC_OUT_W-1:0] w);
        int n;
        bit hs;
        res_valid = 1'b1;
        res_data  = w;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 300) begin
            @(negedge aclk);
            hs = res_ready;
            @(posedge aclk);
            #1;
            n++;
        end
        res_valid = 1'b0;
        if (!hs) begin
            check(1'b0, "res_timeout", 256'(0), 256'(1));
        end else begin
            for (int j = 0; j < N; j++) begin
                sum_q.push_back({j == N - 1,
                                 OUT_W'(w >> ((N - 1 - j) * OUT_W))});
            end
        end
    endtask

    function automatic logic [ACC_OUT_W-1:0] rand_res();
        logic [ACC_OUT_W-1:0] w;
        w = '0;
        for (int j = 0; j < N; j++) w = (w << OUT_W) | ACC_OUT_W'(OUT_W'($urandom));
        return w;
    endfunction

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((acc_q.size() != 0 || sum_q.size() != 0) && n < 3000) begin
            @(posedge aclk);
            n++;
        end
        #1;
        check(acc_q.size() == 0 && sum_q.size() == 0, nm,
              256'(acc_q.size() + sum_q.size()), 256'(0));
    endtask

    task automatic check_reset_vals();
        check(s_elem_ready == 1'b1, "rst_s_ready", 256'(s_elem_ready), 256'(1));
        check(acc_valid == 1'b0, "rst_acc_valid", 256'(acc_valid), 256'(0));
        check(acc_data == '0, "rst_acc_data", 256'(acc_data), 256'(0));
        check(res_ready == 1'b1, "rst_res_ready", 256'(res_ready), 256'(1));
        check(m_elem_valid == 1'b0, "rst_m_valid", 256'(m_elem_valid), 256'(0));
        check(m_elem_data == '0, "rst_m_data", 256'(m_elem_data), 256'(0));
        check(m_elem_last == 1'b0, "rst_m_last", 256'(m_elem_last), 256'(0));
`ifdef VADD_HOST_LASTCHK_EN
        check(frame_err == 1'b0, "rst_frame_err", 256'(frame_err), 256'(0));
`endif
    endtask

    initial begin
        logic [ACC_OUT_W-1:0] w;
        aresetn      = 1'b0;
        s_elem_data  = '0;
        s_elem_valid = 1'b0;
        res_data     = '0;
        res_valid    = 1'b0;
        acc_force    = 1'b0;
        acc_rnd      = 1'b0;
        acc_rand_en  = 1'b0;
        m_force      = 1'b1;
        m_tog        = 1'b0;
        m_rnd        = 1'b0;
        m_mode       = 0;
`ifdef VADD_HOST_LASTCHK_EN
        s_elem_last  = 1'b0;
`endif
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_vals();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // elements 1..22 back-to-back, accelerator stalled for 5 cycles
        pack_frame(1'b1, 0, BEATS);
        @(negedge aclk);
        check(acc_valid == 1'b1, "pack_latency", 256'(acc_valid), 256'(1));
        check(acc_data[219:210] == 10'd1, "slot0", 256'(acc_data[219:210]), 256'(1));
        check(acc_data[9:0] == 10'd22, "slot21", 256'(acc_data[9:0]), 256'(22));
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check(s_elem_ready == 1'b0, "stall_s_ready", 256'(s_elem_ready), 256'(0));
            check(acc_valid == 1'b1, "stall_acc_valid", 256'(acc_valid), 256'(1));
        end
        @(posedge aclk);
        #1;
        acc_force = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check(s_elem_ready == 1'b1, "s_ready_after_acc", 256'(s_elem_ready), 256'(1));
        check(acc_valid == 1'b0, "acc_valid_drop", 256'(acc_valid), 256'(0));
        check(acc_q.size() == 0, "acc_popped", 256'(acc_q.size()), 256'(0));
        @(posedge aclk);
        #1;

        // slot j = j+100, downstream always ready
        w = '0;
        for (int j = 0; j < N; j++) w = (w << OUT_W) | ACC_OUT_W'(j + 100);
        send_result(w);
        for (int i = 0; i < N; i++) begin
            @(negedge aclk);
            check(m_elem_valid == 1'b1, "emit_valid", 256'(m_elem_valid), 256'(1));
            check(m_elem_data == OUT_W'(100 + i), "emit_data",
                  256'(m_elem_data), 256'(100 + i));
            @(posedge aclk);
        end
        @(negedge aclk);
        check(res_ready == 1'b1, "res_ready_back", 256'(res_ready), 256'(1));
        check(m_elem_valid == 1'b0, "emit_done", 256'(m_elem_valid), 256'(0));
        @(posedge aclk);
        #1;

        // toggling downstream ready
        m_mode = 1;
        send_result(rand_res());
        drain("drain_toggle");

        // reset mid-pack and mid-emit
        send_result(rand_res());
        pack_frame(1'b0, 0, 7);
        check(m_elem_valid == 1'b1, "mid_emit", 256'(m_elem_valid), 256'(1));
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        sum_q.delete();
        @(negedge aclk);
        check_reset_vals();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        pack_frame(1'b0, 0, BEATS);
        drain("drain_after_reset");

`ifdef VADD_HOST_LASTCHK_EN
        // early last on beat 10 discards the partial frame
        for (int i = 0; i < 11; i++) begin
            s_elem_last = (i == 10);
            put_beat(IN_W'($urandom));
        end
        s_elem_valid = 1'b0;
        s_elem_last  = 1'b0;
        @(negedge aclk);
        check(frame_err == 1'b1, "frame_err_pulse", 256'(frame_err), 256'(1));
        check(acc_valid == 1'b0, "early_no_acc", 256'(acc_valid), 256'(0));
        @(posedge aclk);
        @(negedge aclk);
        check(frame_err == 1'b0, "frame_err_clear", 256'(frame_err), 256'(0));
        @(posedge aclk);
        #1;
        pack_frame(1'b0, 0, BEATS);
        drain("drain_after_early_last");
`endif

        // concurrent random traffic with random backpressure
        acc_rand_en = 1'b1;
        m_mode      = 2;
        fork
            begin
                for (int f = 0; f < 6; f++) pack_frame(1'b0, 2, BEATS);
            end
            begin
                for (int r = 0; r < 6; r++) send_result(rand_res());
            end
        join
        drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vector_add_11_stream_host.md
# vector_add_11_stream_host

Host-side stream bridge for the 11-element vector-add accelerator's AXI-Stream wrapper. The pack path collects 22 narrow element beats (A0..A10, then B0..B10) and presents them as one 220-bit operand word. The unpack path takes the 121-bit result word and replays it as 11 narrow sum beats, S0 first, with a last marker. It sits between a DMA/element stream and the accelerator wrapper.

## Interface
- N, 11, elements per vector
- IN_W, 10, operand element width
- OUT_W, 11, sum element width
- ACC_IN_W, 2*N*IN_W (220), packed operand word width
- ACC_OUT_W, N*OUT_W (121), packed result word width

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous, active-low reset
- s_elem_data  in  IN_W  operand element
- s_elem_valid  in  1  operand element valid
- s_elem_ready  out  1  operand element accepted
- acc_data  out  ACC_IN_W  packed operands to accelerator
- acc_valid  out  1  packed word valid
- acc_ready  in  1  accelerator accepts packed word
- res_data  in  ACC_OUT_W  packed sums from accelerator
- res_valid  in  1  result valid
- res_ready  out  1  result accepted
- m_elem_data  out  OUT_W  sum element
- m_elem_valid  out  1  sum element valid
- m_elem_last  out  1  high on S10 beat
- m_elem_ready  in  1  downstream accepts sum element

## Operation
- The two paths are independent and may run concurrently. All outputs are registered.
- Pack FSM states:
  - FILL: s_elem_ready=1. Each handshake writes the beat into slot k (k=0..21) and increments k.
  - Slot k maps to acc_data[ACC_IN_W-1-k*IN_W -: IN_W], so beat 0 (A0) lands in [219:210] and beat 21 (B10) in [9:0].
  - On the handshake with k=21: go to SEND, acc_valid<=1, k<=0.
  - SEND: s_elem_ready=0. acc_data is held stable. On acc_valid&&acc_ready: acc_valid<=0, s_elem_ready<=1, go to FILL.
- Unpack FSM states:
  - IDLE: res_ready=1. On res_valid&&res_ready: capture res_data into the shift register, res_ready<=0, go to EMIT with m_elem_valid<=1, index j=0.
  - EMIT: m_elem_data = res_word[ACC_OUT_W-1-j*OUT_W -: OUT_W], so S0 = [120:110]. m_elem_last = (j==N-1).
  - On each m_elem handshake, j increments. On the handshake with j=N-1: m_elem_valid<=0, m_elem_last<=0, res_ready<=1, go to IDLE.
- Data is passed through unaltered; no arithmetic on element values.
- Reset mid-frame discards the partial pack frame and any unemitted sums. No recovery of in-flight data.

## Timing
- Reset values:
  - s_elem_ready=1, acc_valid=0, acc_data=0
  - res_ready=1, m_elem_valid=0, m_elem_data=0, m_elem_last=0
  - both FSMs at FILL/IDLE, k=j=0
- Pack latency: 22nd beat accepted at cycle t gives acc_valid=1 at t+1. The earliest next s_elem_ready=1 is the cycle after the acc handshake.
- Unpack latency: result accepted at t gives S0 valid at t+1. With m_elem_ready held high, S0..S10 appear on t+1..t+11, and res_ready=1 again at t+12.
- Throughput is one beat per cycle on each element stream.
- Backpressure: while acc_valid is high and acc_ready is low, acc_valid/acc_data stay stable indefinitely. While m_elem_valid is high and m_elem_ready is low, m_elem_data/last stay stable.
- valid never depends combinationally on ready. All handshakes are sampled at the rising edge of aclk.

## Configuration
- VADD_HOST_LASTCHK_EN:
  - Defined: adds input s_elem_last (1 bit) and output frame_err (1 bit, reset 0).
  - s_elem_last must be high exactly on beat k=21. If it is high on k<21, the partial frame is discarded (k<=0, stays in FILL, no acc_valid). If it is low on k=21, the word is still sent.
  - In both mismatch cases frame_err pulses high for one cycle.
  - Undefined: no s_elem_last/frame_err ports. Framing is by count only.

## Structure
- Package vadd_host_pkg holds N, IN_W, OUT_W, the derived word widths, and the pack/unpack state enums.
- The unpack path is one sub-module, vadd_elem_unpacker: res handshake, capture register, index counter, m_elem outputs.
- The pack path stays in the top.

## Test plan
- Feed elements 1..22 back-to-back -> acc_valid one cycle after the 22nd beat; acc_data[219:210]=1, acc_data[9:0]=22; s_elem_ready low until the acc handshake.
- Hold acc_ready=0 for 5 cycles after acc_valid -> acc_data is stable and s_elem_ready stays 0. Raise acc_ready -> s_elem_ready=1 on the next cycle.
- res_data with slot j = j+100 and m_elem_ready=1 -> beats 100..110 on consecutive cycles, m_elem_last only on 110, res_ready=1 the cycle after.
- Toggle m_elem_ready every cycle during EMIT -> no beat lost or duplicated; m_elem_data changes only after a handshake.
- Assert aresetn=0 after 7 pack beats and mid-EMIT -> all outputs return to reset values; the next full 22-beat frame packs correctly from slot 0.
- With VADD_HOST_LASTCHK_EN defined, drive s_elem_last on beat 10 -> frame_err pulses, no acc_valid, and the next 22-beat frame is sent normally.
